ppu_chr_arbiter: RTL

- Time-shares the single 16-bit CHR SRAM between PPU pattern-table fetches and CPU $2007 pattern-table accesses.
- The CPU $2007 accesses arrive already synchronised into the PPU clock domain.
- Replaces the "CPU-always-wins" address mux: CPU accesses are buffered and slotted between PPU fetches, so rendering reads are never corrupted.
- Sits between the PPU render/cfg logic and the SRAM pins; sequences SRAM read and write timing.

---
 rtl/ppu_pkg.sv | 27 ++
 rtl/ppu_chr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CHR SRAM arbiter: FSM state encoding,
// SRAM idle levels and the CPU-to-SRAM address/byte-lane mapping.
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PT_RD,
        ST_CF_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } arb_state_t;

    localparam logic        STROBE_IDLE     = 1'b1;
    localparam logic [11:0] SRAM_ADDR_IDLE  = 12'h000;
    localparam logic [15:0] SRAM_WDATA_IDLE = 16'h0000;

    // The CPU sees bytes; bit 3 of its address picks the lane of a 16-bit word.
    function automatic logic [11:0] cfg_sram_addr(input logic [13:0] addr);
        return {addr[12:4], addr[2:0]};
    endfunction

    function automatic logic [15:0] cfg_lane_data(input logic hi, input logic [7:0] data);
        return hi ? {data, 8'h00} : {8'h00, data};
    endfunction

endpackage

// File: rtl/ppu_chr_arbiter.sv
// Time-shares the CHR SRAM between PPU pattern fetches and buffered CPU $2007
// accesses, with a starvation limit so a pending CPU access eventually wins.
module ppu_chr_arbiter
    import ppu_pkg::*;
#(
    parameter int RD_WAIT    = 2,
    parameter int WR_PULSE   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        i_ppu_clk,
    input  logic        i_ppu_rstn,
    input  logic        i_cfg_req,
    input  logic        i_cfg_we,
    input  logic [13:0] i_cfg_addr,
    input  logic [7:0]  i_cfg_wdata,
    output logic        o_cfg_busy,
    output logic        o_cfg_done,
    output logic [7:0]  o_cfg_rdata,
    output logic        o_cfg_drop,
    input  logic        i_pt_req,
    input  logic [11:0] i_pt_addr,
    output logic        o_pt_ready,
    output logic        o_pt_valid,
    output logic [15:0] o_pt_rdata,
    output logic [11:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    input  logic [15:0] i_sram_rdata,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]      RD_LAST    = 8'(RD_WAIT - 1);
    localparam logic [7:0]      WR_LAST    = 8'(WR_PULSE - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [SW-1:0] r_starve;

    logic          r_busy;
    logic          r_buf_we;
    logic [13:0]   r_buf_addr;
    logic [7:0]    r_buf_wdata;

    logic          r_cfg_done, r_cfg_drop, r_pt_valid;
    logic [7:0]    r_cfg_rdata;
    logic [15:0]   r_pt_rdata;

    logic [11:0]   r_sram_addr, w_sram_addr_nxt;
    logic [15:0]   r_sram_wdata, w_sram_wdata_nxt;
    logic          r_we_n, w_we_n_nxt;
    logic          r_oe_n, w_oe_n_nxt;
    logic          r_ub_n, w_ub_n_nxt;
    logic          r_lb_n, w_lb_n_nxt;

    logic          w_cf_pending, w_np_done, w_cf_hi, w_pt_ready;
    logic          w_pt_grant, w_cf_grant, w_pt_done, w_cf_rd_done, w_cf_wr_done;

    // Accesses above $1FFF never touch the SRAM; they complete from the buffer.
    assign w_cf_pending = r_busy & ~r_buf_addr[13];
    assign w_np_done    = r_busy &  r_buf_addr[13];
    assign w_cf_hi      = r_buf_addr[3];
    assign w_pt_ready   = (r_state == ST_IDLE) & ~(r_busy & (r_starve == STARVE_LIM));

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sram_addr_nxt  = r_sram_addr;
        w_sram_wdata_nxt = r_sram_wdata;
        w_we_n_nxt       = STROBE_IDLE;
        w_oe_n_nxt       = r_oe_n;
        w_ub_n_nxt       = r_ub_n;
        w_lb_n_nxt       = r_lb_n;
        w_pt_grant       = 1'b0;
        w_cf_grant       = 1'b0;
        w_pt_done        = 1'b0;
        w_cf_rd_done     = 1'b0;
        w_cf_wr_done     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt        = 8'd0;
                w_sram_addr_nxt  = SRAM_ADDR_IDLE;
                w_sram_wdata_nxt = SRAM_WDATA_IDLE;
                w_oe_n_nxt       = STROBE_IDLE;
                w_ub_n_nxt       = STROBE_IDLE;
                w_lb_n_nxt       = STROBE_IDLE;
                if (i_pt_req && w_pt_ready) begin
                    w_pt_grant      = 1'b1;
                    w_state_nxt     = ST_PT_RD;
                    w_sram_addr_nxt = i_pt_addr;
                    w_oe_n_nxt      = 1'b0;
                    w_ub_n_nxt      = 1'b0;
                    w_lb_n_nxt      = 1'b0;
                end else if (w_cf_pending) begin
                    w_cf_grant      = 1'b1;
                    w_sram_addr_nxt = cfg_sram_addr(r_buf_addr);
                    w_ub_n_nxt      = ~w_cf_hi;
                    w_lb_n_nxt      = w_cf_hi;
                    if (r_buf_we) begin
                        w_state_nxt      = ST_WR_SETUP;
                        w_sram_wdata_nxt = cfg_lane_data(w_cf_hi, r_buf_wdata);
                    end else begin
                        w_state_nxt = ST_CF_RD;
                        w_oe_n_nxt  = 1'b0;
                    end
                end
            end
            ST_PT_RD, ST_CF_RD: begin
                if (r_cnt == RD_LAST) begin
                    w_pt_done        = (r_state == ST_PT_RD);
                    w_cf_rd_done     = (r_state == ST_CF_RD);
                    w_state_nxt      = ST_IDLE;
                    w_sram_addr_nxt  = SRAM_ADDR_IDLE;
                    w_sram_wdata_nxt = SRAM_WDATA_IDLE;
                    w_oe_n_nxt       = STROBE_IDLE;
                    w_ub_n_nxt       = STROBE_IDLE;
                    w_lb_n_nxt       = STROBE_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_cnt_nxt   = 8'd0;
                w_we_n_nxt  = 1'b0;
            end
            ST_WR_PULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_state_nxt = ST_WR_HOLD;
                end else begin
                    w_cnt_nxt  = r_cnt + 8'd1;
                    w_we_n_nxt = 1'b0;
                end
            end
            ST_WR_HOLD: begin
                w_cf_wr_done     = 1'b1;
                w_state_nxt      = ST_IDLE;
                w_sram_addr_nxt  = SRAM_ADDR_IDLE;
                w_sram_wdata_nxt = SRAM_WDATA_IDLE;
                w_oe_n_nxt       = STROBE_IDLE;
                w_ub_n_nxt       = STROBE_IDLE;
                w_lb_n_nxt       = STROBE_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
        if (!i_ppu_rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_sram_addr  <= SRAM_ADDR_IDLE;
            r_sram_wdata <= SRAM_WDATA_IDLE;
            r_we_n       <= STROBE_IDLE;
            r_oe_n       <= STROBE_IDLE;
            r_ub_n       <= STROBE_IDLE;
            r_lb_n       <= STROBE_IDLE;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_sram_wdata <= w_sram_wdata_nxt;
            r_we_n       <= w_we_n_nxt;
            r_oe_n       <= w_oe_n_nxt;
            r_ub_n       <= w_ub_n_nxt;
            r_lb_n       <= w_lb_n_nxt;
        end
    end

    // One-entry CPU buffer plus the count of PPU grants taken while it waits.
    always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
        if (!i_ppu_rstn) begin
            r_busy      <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= 14'h0;
            r_buf_wdata <= 8'h0;
            r_cfg_drop  <= 1'b0;
            r_starve    <= '0;
        end else begin
            r_cfg_drop <= i_cfg_req & r_busy;
            if (!r_busy) begin
                if (i_cfg_req) begin
                    r_busy      <= 1'b1;
                    r_buf_we    <= i_cfg_we;
                    r_buf_addr  <= i_cfg_addr;
                    r_buf_wdata <= i_cfg_wdata;
                end
            end else if (w_cf_rd_done || w_cf_wr_done || w_np_done) begin
                r_busy <= 1'b0;
            end
            if (!r_busy || w_cf_grant) begin
                r_starve <= '0;
            end else if (w_pt_grant && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
        if (!i_ppu_rstn) begin
            r_cfg_done  <= 1'b0;
            r_cfg_rdata <= 8'h0;
            r_pt_valid  <= 1'b0;
            r_pt_rdata  <= 16'h0;
        end else begin
            r_cfg_done <= w_cf_rd_done | w_cf_wr_done | w_np_done;
            r_pt_valid <= w_pt_done;
            if (w_pt_done) begin
                r_pt_rdata <= i_sram_rdata;
            end
            if (w_np_done) begin
                r_cfg_rdata <= 8'h00;
            end else if (w_cf_rd_done) begin
                r_cfg_rdata <= w_cf_hi ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
            end
        end
    end

    assign o_cfg_busy   = r_busy;
    assign o_cfg_done   = r_cfg_done;
    assign o_cfg_rdata  = r_cfg_rdata;
    assign o_cfg_drop   = r_cfg_drop;
    assign o_pt_ready   = w_pt_ready;
    assign o_pt_valid   = r_pt_valid;
    assign o_pt_rdata   = r_pt_rdata;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_ub_n  = r_ub_n;
    assign o_sram_lb_n  = r_lb_n;

endmodule
